// File: rtl/uart_tx_bridge_if.sv
// Input word stream (valid/ready) feeding the UART Tx bridge.
// The slave modport is used by the bridge and the master modport by the producer.
interface uart_tx_bridge_if #(
    parameter int DATA_W = 8
);
    logic              s_valid_i;
    logic              s_ready_o;
    logic [DATA_W-1:0] s_data_i;

    modport slave  (input  s_valid_i, input  s_data_i, output s_ready_o);
    modport master (output s_valid_i, output s_data_i, input  s_ready_o);
endinterface

// File: rtl/uart_tx_bridge.sv
// uart_tx_bridge: queues words in a FIFO and hands them one at a time to the
// UART controller through the tx_start/tx_busy/tx_done handshake.
// Optional macro UART_TX_BRIDGE_LEVEL_EN adds the level_o occupancy port.
module uart_tx_bridge #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_W     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    uart_tx_bridge_if.slave            s,
    output logic                       tx_start_o,
    output logic [MAX_UART_DATA_W-1:0] tx_data_o,
    input  logic                       tx_busy_i,
    input  logic                       tx_done_i,
    output logic                       empty_o,
    output logic                       full_o
`ifdef UART_TX_BRIDGE_LEVEL_EN
    ,
    output logic [FIFO_ADDR_W:0]       level_o
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam logic [FIFO_ADDR_W:0] DEPTH_C = (FIFO_ADDR_W+1)'(FIFO_DEPTH);

    logic [MAX_UART_DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_W:0]       count_q, count_d;
    state_e                     state_q, state_d;
    logic [MAX_UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                       tx_start_q, tx_start_d;
    logic                       push, pop;

    // Flags come straight from the registered occupancy, so a pop in the same
    // cycle never opens room for a push while full.
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign s.s_ready_o = ~full_o;

    assign push = s.s_valid_i & ~full_o;
    assign pop  = (state_q == IDLE) & en_i & ~empty_o;

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
`ifdef UART_TX_BRIDGE_LEVEL_EN
    assign level_o = count_q;
`endif

    // FIFO pointer and occupancy bookkeeping; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + FIFO_ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + FIFO_ADDR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (FIFO_ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Launch FSM: pop into the data register, hold start until the controller
    // reports busy, then wait for its done pulse. Stray busy/done are ignored.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                // start drops on the same edge busy is seen
                tx_start_d = ~tx_busy_i;
                if (tx_busy_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset flushes the FIFO and drops any in-flight character.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= s.s_data_i;
    end

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Self-checking bench for uart_tx_bridge: directed handshake/reset scenarios
// plus a randomized producer/controller run scored against a word queue.
// Build with +define+UART_TX_BRIDGE_LEVEL_EN to also check level_o.
module tb_uart_tx_bridge;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          en_i = 1'b0;
    logic          tx_busy_i = 1'b0;
    logic          tx_done_i = 1'b0;
    logic          tx_start_o, empty_o, full_o;
    logic [DW-1:0] tx_data_o;
`ifdef UART_TX_BRIDGE_LEVEL_EN
    logic [AW:0]   level_o;
`endif

    uart_tx_bridge_if #(.DATA_W(DW)) s_if ();

    uart_tx_bridge #(
        .MAX_UART_DATA_W(DW), .FIFO_DEPTH(DEPTH), .FIFO_ADDR_W(AW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .s(s_if.slave),
        .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i),
        .empty_o(empty_o), .full_o(full_o)
`ifdef UART_TX_BRIDGE_LEVEL_EN
        , .level_o(level_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int pushed = 0;
    int served = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // one clock, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_start_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("start_seen", ok, 1);
    endtask

    // behavioural controller: accept after pre cycles, stay busy hold cycles
    task automatic serve(input int pre, input int hold);
        bit ok;
        logic [DW-1:0] d;
        logic [31:0] e;
        wait_start(ok);
        if (!ok) return;
        d = tx_data_o;
        e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
        chk("launch_data", d, e);
        for (int i = 0; i < pre; i++) begin
            tick();
            chk("start_hold", tx_start_o, 1);
        end
        tx_busy_i = 1'b1;
        tick();
        chk("start_drop", tx_start_o, 0);
        for (int i = 0; i < hold; i++) tick();
        chk("data_stable", tx_data_o, d);
        tx_busy_i = 1'b0;
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        served++;
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i  = d;
        tick();
        s_if.s_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit bad;
        int model_cnt;
        s_if.s_valid_i = 1'b0;
        s_if.s_data_i  = '0;

        // reset held for three cycles
        rst_ni = 1'b0;
        repeat (3) tick();
        chk("rst_start", tx_start_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_ready", s_if.s_ready_o, 1);
        chk("rst_data", tx_data_o, 0);
`ifdef UART_TX_BRIDGE_LEVEL_EN
        chk("rst_level", level_o, 0);
`endif
        rst_ni = 1'b1;
        en_i   = 1'b1;
        tick();

        // single word 0xA5 pushed at edge N
        push_one(8'hA5);                       // now just after N
        chk("sw_notempty_N", empty_o, 0);
        chk("sw_start_N", tx_start_o, 0);
        tick();                                // N+1: popped
        chk("sw_empty_N1", empty_o, 1);
        chk("sw_data_N1", tx_data_o, 8'hA5);
        chk("sw_start_N1", tx_start_o, 0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("sw_start_on", tx_start_o, 1);
        end
        tx_busy_i = 1'b1;                      // seen at N+6
        tick();
        chk("sw_start_N6", tx_start_o, 0);
        chk("sw_data_N6", tx_data_o, 8'hA5);
        repeat (14) tick();                    // N+20
        tx_busy_i = 1'b0;
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        repeat (3) tick();
        chk("sw_idle_start", tx_start_o, 0);
        chk("sw_idle_empty", empty_o, 1);

        // stray done while waiting in LAUNCH
        exp_q.push_back(8'h3C);
        push_one(8'h3C);
        tick();
        tick();
        chk("stray_start", tx_start_o, 1);
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        chk("stray_hold1", tx_start_o, 1);
        tick();
        chk("stray_hold2", tx_start_o, 1);
        serve(1, 2);
        repeat (2) tick();

        // fill with en_i low: 17 offered, 16 accepted
        en_i = 1'b0;
        model_cnt = 0;
        chk("fill_pre_empty", empty_o, 1);
        for (int i = 0; i < 17; i++) begin
            chk("fill_ready", s_if.s_ready_o, (model_cnt < DEPTH) ? 1 : 0);
            push_one(DW'(i));
            if (model_cnt < DEPTH) begin
                exp_q.push_back(DW'(i));
                model_cnt++;
            end
        end
        chk("fill_full", full_o, 1);
        chk("fill_ready_lo", s_if.s_ready_o, 0);
        chk("fill_no_launch", tx_start_o, 0);
`ifdef UART_TX_BRIDGE_LEVEL_EN
        chk("fill_level", level_o, DEPTH);
`endif
        en_i = 1'b1;
        repeat (16) serve($urandom_range(0, 3), $urandom_range(1, 4));
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (tx_start_o) bad = 1'b1;
        end
        chk("fill_no_extra", bad, 0);
        chk("fill_drained", empty_o, 1);
        chk("fill_q_empty", exp_q.size(), 0);

        // reset during WAIT_DONE with four words queued
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) push_one(DW'($urandom));
        en_i = 1'b1;
        wait_start(ok);
        tx_busy_i = 1'b1;
        tick();
        tick();                                // in WAIT_DONE
        rst_ni = 1'b0;
        tick();
        chk("mrst_start", tx_start_o, 0);
        chk("mrst_empty", empty_o, 1);
        chk("mrst_full", full_o, 0);
        chk("mrst_data", tx_data_o, 0);
        rst_ni = 1'b1;
        tick();
        tx_busy_i = 1'b0;
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (tx_start_o) bad = 1'b1;
        end
        chk("mrst_no_launch", bad, 0);
        chk("mrst_still_empty", empty_o, 1);

        // randomized producer against a randomized controller
        pushed = 0;
        served = 0;
        exp_q.delete();
        fork
            begin : producer
                int guard;
                logic [DW-1:0] d;
                for (int k = 0; k < 40; k++) begin
                    guard = 0;
                    while ((pushed - served) >= DEPTH && guard < 5000) begin
                        tick();
                        guard++;
                    end
                    repeat ($urandom_range(0, 3)) tick();
                    chk("rand_ready", s_if.s_ready_o, 1);
                    d = DW'($urandom);
                    exp_q.push_back(d);
                    push_one(d);
                    pushed++;
                end
            end
            begin : consumer
                bit gbad;
                for (int k = 0; k < 40; k++) begin
                    serve($urandom_range(0, 3), $urandom_range(1, 4));
                    if ($urandom_range(0, 1) == 1) begin
                        en_i = 1'b0;
                        gbad = 1'b0;
                        repeat ($urandom_range(1, 4)) begin
                            tick();
                            if (tx_start_o) gbad = 1'b1;
                        end
                        chk("en_gate", gbad, 0);
                        en_i = 1'b1;
                    end
                end
            end
        join
        repeat (5) tick();
        chk("rand_q_empty", exp_q.size(), 0);
        chk("rand_empty", empty_o, 1);
        chk("rand_served", served, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
